mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
- Target side of the byte-wide memory bus driven by the memory controller (mem_a / mem_dout / mem_wr out, mem_din in).
- Holds the 128 KiB main RAM and decodes a small memory-mapped I/O window.
- The window bridges to a host byte stream through an RX FIFO (host→CPU) and a TX FIFO (CPU→host).
- Sits at top level between the CPU core and the host-communication link.

Parameters:
RAM_ADDR_WIDTH, 17, RAM word-address bits; RAM is 2^RAM_ADDR_WIDTH bytes.
FIFO_DEPTH_LOG2, 3, log2 of entries in each of the RX and TX FIFOs (8 entries).

Ports:
clk_in  input  1  system clock, all state on rising edge
rst_in  input  1  asynchronous active-low reset
rdy_in  input  1  global ready; when low, bus-side state freezes (RAM, FIFO pointers via bus, mem_din hold)
mem_a  input  32  byte address from controller; bits 17:0 decoded
mem_dout  input  8  write data from controller
mem_wr  input  1  1 = write this cycle, 0 = read
mem_din  output  8  read data to controller, registered
io_rx_valid  input  1  host byte available
io_rx_data  input  8  host byte
io_rx_ready  output  1  RX FIFO can accept (not full)
io_tx_valid  output  1  TX FIFO non-empty
io_tx_data  output  8  TX FIFO head byte
io_tx_ready  input  1  host consumes head byte

Behaviour:
- Decode: a[17:16]==2'b11 → I/O; otherwise RAM at a[RAM_ADDR_WIDTH-1:0].
- I/O registers, offset a[3:0]:
  - 0x0: read pops RX, write pushes TX.
  - 0x4: read status {6'b0, tx_full, rx_nonempty}.
  - 0x8: read sticky {6'b0, rx_overflow, tx_overflow}; any write clears both bits.
  - Other offsets: read 0, write ignored.
- Read latency: exactly 1 cycle. mem_din updates on the edge where {mem_a, mem_wr=0} is sampled and is valid the whole following cycle. Controller holds mem_a ≥2 cycles; repeated RAM reads of the same address are harmless.
- Writes: on any edge with mem_wr=1 and rdy_in=1, RAM[a] <= mem_dout. mem_din holds its previous value on write cycles.
- Access-start detection: register last sampled {mem_a[17:0], mem_wr} as prev. An I/O side effect (RX pop) fires only on the first sampled cycle of a read to 0x30000, i.e. current differs from prev, or the previous cycle was a write. Holding the address never double-pops.
- RX pop when empty: mem_din = 8'h00, pointers unchanged.
- TX push: one push per sampled mem_wr=1 cycle at 0x30000.
  - If full: byte dropped, tx_overflow <= 1.
  - Push and host pop in the same cycle while full: the pop frees the slot and the push succeeds.
- RX fill: io_rx_valid & io_rx_ready pushes io_rx_data. This host side runs regardless of rdy_in.
  - io_rx_valid while full: byte dropped, rx_overflow <= 1.
  - Simultaneous push and pop (RX or TX): count unchanged, both pointers advance.
- FIFOs: circular buffers, pointers wrap modulo 2^FIFO_DEPTH_LOG2. Count has FIFO_DEPTH_LOG2+1 bits; full = count==2^FIFO_DEPTH_LOG2.
- io_tx_data is the combinational head entry, valid whenever io_tx_valid=1.
- rdy_in=0: no RAM write, no bus-side pop/push, mem_din held, prev held. Host-side TX pop and RX push still proceed.
- Reset (rst_in low, asynchronous):
  - mem_din=0.
  - FIFOs empty: io_tx_valid=0, io_rx_ready=1.
  - Overflow flags 0, prev={18'h3FFFF, 1}.
  - RAM contents not reset (preloaded by simulation/bitstream).
  - Reset mid-access drops the access; FIFO contents lost.
- mem_a bits 31:18 ignored (aliasing allowed).

Test Plan:
- Write 0x5A to 0x00010 (mem_wr=1 for one cycle), then read 0x00010 holding address 2 cycles → mem_din=0x5A on the cycle after first sample. Reads of 0x00011 after reset preload return the preloaded value.
- Host pushes 0x41,0x42 via io_rx; bus reads 0x30004 → 0x01. Two separate reads of 0x30000, each address held 2 cycles → 0x41 then 0x42 (no double pop). Next status read → 0x00. Further 0x30000 read → 0x00.
- Write 0x48,0x49 to 0x30000 with io_tx_ready=0 → io_tx_valid=1, io_tx_data=0x48. Raise io_tx_ready one cycle → io_tx_data=0x49.
- Fill TX with 8 writes, 9th write 0x77 → dropped, 0x30008 reads 0x01. Write 0x30008 → reads 0x00. Drain → exactly 8 bytes in order.
- Hold rdy_in=0 while mem_wr=1 at 0x00020 with data 0xFF → RAM unchanged (later read returns old value); host RX push during stall still accepted.
- Assert rst_in low mid-way through a 4-byte read with TX holding 3 bytes → immediately mem_din=0, io_tx_valid=0, io_rx_ready=1, flags 0.

Source files
------------

// File: rtl/mem_bus_responder_if.sv
// Byte-wide memory bus between the memory controller (master) and the
// RAM / I/O responder (slave).
interface mem_bus_responder_if;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;

    modport master (output mem_a, output mem_dout, output mem_wr, input mem_din);
    modport slave  (input mem_a, input mem_dout, input mem_wr, output mem_din);
endinterface

// File: rtl/mem_bus_responder.sv
// Memory-bus target: main RAM plus an I/O window that bridges the CPU to a
// host byte stream through an RX FIFO (host->CPU) and a TX FIFO (CPU->host).
module mem_bus_responder #(
    parameter int RAM_ADDR_WIDTH  = 17,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    mem_bus_responder_if.slave   bus,
    input  logic                 io_rx_valid,
    input  logic [7:0]           io_rx_data,
    output logic                 io_rx_ready,
    output logic                 io_tx_valid,
    output logic [7:0]           io_tx_data,
    input  logic                 io_tx_ready
);
    localparam int PW = FIFO_DEPTH_LOG2;
    localparam logic [PW:0] FULL_CNT = {1'b1, {PW{1'b0}}};

    logic [7:0]    ram    [0:(1 << RAM_ADDR_WIDTH) - 1];
    logic [7:0]    rx_mem [0:(1 << PW) - 1];
    logic [7:0]    tx_mem [0:(1 << PW) - 1];

    logic [PW-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
    logic [PW:0]   rx_cnt, tx_cnt;
    logic          rx_ovf, tx_ovf;
    logic [18:0]   prev;
    logic [7:0]    ram_q, io_q;
    logic          src_ram;

    logic [18:0]   cur;
    logic          is_io, rd_start, bus_rd, bus_wr;
    logic [3:0]    off;
    logic          rx_full, rx_nonempty, tx_full, tx_nonempty;
    logic          rx_push, rx_pop, tx_push_req, tx_push, tx_pop;
    logic          ram_we, ram_rd, io_rd, sticky_clr;
    logic [7:0]    io_rd_val;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;

    wire unused_hi = ^bus.mem_a[31:18];

    assign cur         = {bus.mem_a[17:0], bus.mem_wr};
    assign is_io       = (bus.mem_a[17:16] == 2'b11);
    assign off         = bus.mem_a[3:0];
    assign ram_addr    = bus.mem_a[RAM_ADDR_WIDTH-1:0];
    // A read starts a new access when the sampled access changed or the last one was a write.
    assign rd_start    = (cur != prev) || prev[0];
    assign bus_rd      = rdy_in && !bus.mem_wr;
    assign bus_wr      = rdy_in && bus.mem_wr;

    assign rx_full     = (rx_cnt == FULL_CNT);
    assign rx_nonempty = (rx_cnt != '0);
    assign tx_full     = (tx_cnt == FULL_CNT);
    assign tx_nonempty = (tx_cnt != '0);

    assign rx_push     = io_rx_valid && !rx_full;
    assign rx_pop      = bus_rd && is_io && (off == 4'h0) && rd_start && rx_nonempty;
    assign tx_pop      = io_tx_ready && tx_nonempty;
    assign tx_push_req = bus_wr && is_io && (off == 4'h0);
    // A host pop in the same cycle frees the slot for a push into a full FIFO.
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign sticky_clr  = bus_wr && is_io && (off == 4'h8);

    assign ram_we      = bus_wr && !is_io;
    assign ram_rd      = bus_rd && !is_io;
    assign io_rd       = bus_rd && is_io;

    assign io_rx_ready = !rx_full;
    assign io_tx_valid = tx_nonempty;
    assign io_tx_data  = tx_mem[tx_rd_ptr];
    assign bus.mem_din = src_ram ? ram_q : io_q;

    always_comb begin
        io_rd_val = 8'h00;
        case (off)
            4'h0:    io_rd_val = rd_start ? (rx_nonempty ? rx_mem[rx_rd_ptr] : 8'h00) : io_q;
            4'h4:    io_rd_val = {6'b0, tx_full, rx_nonempty};
            4'h8:    io_rd_val = {6'b0, rx_ovf, tx_ovf};
            default: io_rd_val = 8'h00;
        endcase
    end

    // RAM and FIFO storage carry no reset.
    always_ff @(posedge clk_in) begin
        if (ram_we) ram[ram_addr] <= bus.mem_dout;
        if (ram_rd) ram_q <= ram[ram_addr];
        if (rx_push) rx_mem[rx_wr_ptr] <= io_rx_data;
        if (tx_push) tx_mem[tx_wr_ptr] <= bus.mem_dout;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            io_q      <= 8'h00;
            src_ram   <= 1'b0;
            prev      <= {18'h3FFFF, 1'b1};
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            rx_cnt    <= '0;
            tx_cnt    <= '0;
            rx_ovf    <= 1'b0;
            tx_ovf    <= 1'b0;
        end else begin
            if (rdy_in) prev <= cur;
            if (ram_rd) src_ram <= 1'b1;
            if (io_rd) begin
                src_ram <= 1'b0;
                io_q    <= io_rd_val;
            end

            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
            else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;

            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
            else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;

            if (sticky_clr) begin
                rx_ovf <= 1'b0;
                tx_ovf <= 1'b0;
            end
            if (io_rx_valid && rx_full)               rx_ovf <= 1'b1;
            if (tx_push_req && tx_full && !tx_pop)    tx_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: RAM, RX/TX FIFO window, stall and reset.
module tb_mem_bus_responder;
    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       rdy_in = 1'b1;
    logic       io_rx_valid = 1'b0;
    logic [7:0] io_rx_data = 8'h00;
    logic       io_tx_ready = 1'b0;
    wire        io_rx_ready;
    wire        io_tx_valid;
    wire  [7:0] io_tx_data;

    mem_bus_responder_if bus();

    mem_bus_responder #(.RAM_ADDR_WIDTH(17), .FIFO_DEPTH_LOG2(3)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .bus         (bus),
        .io_rx_valid (io_rx_valid),
        .io_rx_data  (io_rx_data),
        .io_rx_ready (io_rx_ready),
        .io_tx_valid (io_tx_valid),
        .io_tx_data  (io_tx_data),
        .io_tx_ready (io_tx_ready)
    );

    always #5 clk_in = ~clk_in;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_model[$];
    logic [7:0] tx_model[$];
    logic       rx_ovf_exp = 1'b0;
    logic       tx_ovf_exp = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_bus();
        bus.mem_a  = 32'h0;
        bus.mem_wr = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [7:0] data);
        bus.mem_a    = addr;
        bus.mem_dout = data;
        bus.mem_wr   = 1'b1;
        if (addr[17:16] == 2'b11) begin
            if (addr[3:0] == 4'h0) begin
                if (tx_model.size() < 8) tx_model.push_back(data);
                else tx_ovf_exp = 1'b1;
            end else if (addr[3:0] == 4'h8) begin
                rx_ovf_exp = 1'b0;
                tx_ovf_exp = 1'b0;
            end
        end
        tick();
        idle_bus();
    endtask

    task automatic bus_read(input logic [31:0] addr, input int n, input string tag);
        logic [7:0] e;
        bus.mem_a  = addr;
        bus.mem_wr = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s: observed %0h expected <empty scoreboard>", tag, bus.mem_din);
            end else begin
                e = exp_q.pop_front();
                check(tag, {24'h0, bus.mem_din}, {24'h0, e});
            end
        end
        idle_bus();
    endtask

    task automatic read_status(input string tag);
        exp_q.push_back({6'b0, tx_model.size() == 8, rx_model.size() != 0});
        bus_read(32'h30004, 1, tag);
    endtask

    task automatic read_sticky(input string tag);
        exp_q.push_back({6'b0, rx_ovf_exp, tx_ovf_exp});
        bus_read(32'h30008, 1, tag);
    endtask

    // One RX pop access held n cycles, then an idle cycle so the next read is a new access.
    task automatic rx_read(input int n, input string tag);
        logic [7:0] e;
        e = (rx_model.size() != 0) ? rx_model.pop_front() : 8'h00;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
        bus_read(32'h30000, n, tag);
        tick();
    endtask

    task automatic host_rx(input logic [7:0] d);
        io_rx_valid = 1'b1;
        io_rx_data  = d;
        if (rx_model.size() < 8) rx_model.push_back(d);
        else rx_ovf_exp = 1'b1;
        tick();
        io_rx_valid = 1'b0;
    endtask

    task automatic host_tx_pop(input string tag);
        check({tag, "_valid"}, {31'h0, io_tx_valid}, 32'h1);
        if (tx_model.size() != 0) check({tag, "_data"}, {24'h0, io_tx_data}, {24'h0, tx_model[0]});
        io_tx_ready = 1'b1;
        tick();
        io_tx_ready = 1'b0;
        if (tx_model.size() != 0) void'(tx_model.pop_front());
    endtask

    initial begin
        bus.mem_a    = 32'h0;
        bus.mem_dout = 8'h00;
        bus.mem_wr   = 1'b0;

        // Reset values
        #2 rst_in = 1'b0;
        #1;
        check("rst_mem_din", {24'h0, bus.mem_din}, 32'h0);
        check("rst_tx_valid", {31'h0, io_tx_valid}, 32'h0);
        check("rst_rx_ready", {31'h0, io_rx_ready}, 32'h1);
        tick();
        tick();
        rst_in = 1'b1;
        tick();

        // RAM write then held read
        bus_write(32'h00010, 8'h5A);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h5A);
        bus_read(32'h00010, 2, "ram_rd_10");
        exp_q.push_back(8'h5A);
        bus_read(32'hABC00010, 1, "ram_alias_10");

        // RAM contents survive reset
        bus_write(32'h00011, 8'h33);
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        tick();
        exp_q.push_back(8'h33);
        bus_read(32'h00011, 1, "ram_preload_11");

        // RX basics: no double pop on held address, empty pop reads 0
        host_rx(8'h41);
        host_rx(8'h42);
        read_status("rx_status_nonempty");
        rx_read(2, "rx_pop_41");
        rx_read(2, "rx_pop_42");
        read_status("rx_status_empty");
        rx_read(2, "rx_pop_empty");

        // TX basics
        bus_write(32'h30000, 8'h48);
        bus_write(32'h30000, 8'h49);
        host_tx_pop("tx_head_48");
        host_tx_pop("tx_head_49");
        check("tx_empty_after_2", {31'h0, io_tx_valid}, 32'h0);

        // TX fill, overflow, sticky clear, ordered drain
        for (int i = 0; i < 8; i++) bus_write(32'h30000, 8'h10 + 8'(i));
        bus_write(32'h30000, 8'h77);
        read_sticky("tx_ovf_set");
        read_status("tx_status_full");
        bus_write(32'h30008, 8'h00);
        read_sticky("sticky_cleared");
        for (int i = 0; i < 8; i++) host_tx_pop("tx_drain");
        check("tx_empty_after_drain", {31'h0, io_tx_valid}, 32'h0);

        // Push into full TX while host pops in the same cycle
        for (int i = 0; i < 8; i++) bus_write(32'h30000, 8'hC0 + 8'(i));
        bus.mem_a    = 32'h30000;
        bus.mem_dout = 8'hA5;
        bus.mem_wr   = 1'b1;
        io_tx_ready  = 1'b1;
        tick();
        io_tx_ready  = 1'b0;
        idle_bus();
        void'(tx_model.pop_front());
        tx_model.push_back(8'hA5);
        read_sticky("tx_full_push_pop_no_ovf");
        read_status("tx_still_full");
        for (int i = 0; i < 8; i++) host_tx_pop("tx_drain2");
        check("tx_empty_after_drain2", {31'h0, io_tx_valid}, 32'h0);

        // RX overflow
        for (int i = 0; i < 8; i++) host_rx(8'h60 + 8'(i));
        check("rx_full_not_ready", {31'h0, io_rx_ready}, 32'h0);
        host_rx(8'h68);
        read_sticky("rx_ovf_set");
        bus_write(32'h30008, 8'hFF);
        read_sticky("rx_ovf_cleared");
        for (int i = 0; i < 8; i++) rx_read(1, "rx_drain");
        check("rx_ready_after_drain", {31'h0, io_rx_ready}, 32'h1);

        // Stall: no RAM write, mem_din held, host RX still accepted
        bus_write(32'h00020, 8'h11);
        exp_q.push_back(8'h11);
        bus_read(32'h00020, 1, "ram_rd_20");
        rdy_in       = 1'b0;
        bus.mem_a    = 32'h00020;
        bus.mem_dout = 8'hFF;
        bus.mem_wr   = 1'b1;
        io_rx_valid  = 1'b1;
        io_rx_data   = 8'h99;
        rx_model.push_back(8'h99);
        tick();
        io_rx_valid  = 1'b0;
        check("stall_wr_din_held", {24'h0, bus.mem_din}, 32'h11);
        bus.mem_a    = 32'h30004;
        bus.mem_wr   = 1'b0;
        tick();
        check("stall_rd_din_held", {24'h0, bus.mem_din}, 32'h11);
        idle_bus();
        rdy_in = 1'b1;
        read_status("stall_rx_accepted");
        exp_q.push_back(8'h11);
        bus_read(32'h00020, 1, "stall_ram_unchanged");
        rx_read(1, "stall_rx_byte");

        // Reset in the middle of a multi-byte read with TX holding bytes
        bus_write(32'h30000, 8'hD1);
        bus_write(32'h30000, 8'hD2);
        bus_write(32'h30000, 8'hD3);
        bus.mem_a = 32'h00010;
        tick();
        check("mid_read_byte0", {24'h0, bus.mem_din}, 32'h5A);
        bus.mem_a = 32'h00011;
        #2 rst_in = 1'b0;
        #1;
        check("midrst_mem_din", {24'h0, bus.mem_din}, 32'h0);
        check("midrst_tx_valid", {31'h0, io_tx_valid}, 32'h0);
        check("midrst_rx_ready", {31'h0, io_rx_ready}, 32'h1);
        tx_model.delete();
        rx_model.delete();
        rx_ovf_exp = 1'b0;
        tx_ovf_exp = 1'b0;
        idle_bus();
        tick();
        rst_in = 1'b1;
        tick();
        read_sticky("midrst_flags");
        read_status("midrst_status");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
